// File: rtl/div_pkg.sv
// Shared types and Q-format constants for the Goldschmidt divider controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_D,
    ISSUE_N,
    DRAIN,
    CAPTURE,
    ZERO
  } ctrl_state_t;

  localparam int          FRAC_IN   = 15;
  localparam int          FRAC_PROD = 30;
  localparam logic [15:0] ONE_Q15   = 16'h8000;
  localparam logic [15:0] SAT_Q15   = 16'hFFFF;

endpackage

// File: rtl/goldschmidt_ctrl_rne.sv
// Round-to-nearest-even from a Q2.30 product down to Q1.15, saturating on
// carry-out. Must stay bit-identical to the rounder inside the datapath.
module goldschmidt_ctrl_rne
  import div_pkg::*;
(
  input  logic [FRAC_PROD:0] x,
  output logic [15:0]        y
);

  logic        guard;
  logic        sticky;
  logic        inc;
  logic [16:0] sum;

  // Guard/sticky decision, then increment with saturation on overflow
  always_comb begin
    guard  = x[FRAC_IN-1];
    sticky = |x[FRAC_IN-2:0];
    inc    = guard & (sticky | x[FRAC_IN]);
    sum    = {1'b0, x[FRAC_PROD:FRAC_IN]} + {16'h0000, inc};
    y      = sum[16] ? SAT_Q15 : sum[15:0];
  end

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; done pulses here after a completed divide
// ISSUE_D | issue D to the datapath (k loads IA on iter 0, else 2-D)
// ISSUE_N | issue N with k held; advance the iteration count
// DRAIN   | last D*K product lands and is discarded
// CAPTURE | final N*K product lands; latch raw and rounded quotient
// ZERO    | divide-by-zero result cycle; datapath untouched
module goldschmidt_ctrl
  import div_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int CNT_W = $clog2(ITERS + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] ia_in,
  input  logic [31:0] dp_result,
  output logic [15:0] dp_n,
  output logic [15:0] dp_d,
  output logic [15:0] dp_ia,
  output logic        dp_kselect,
  output logic        dp_ndselect,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [15:0] quotient,
  output logic [31:0] quotient_raw
);

  ctrl_state_t      state;
  logic [CNT_W-1:0] iter;
  logic [15:0]      n_r;
  logic [15:0]      d_r;
  logic [15:0]      ia_r;
  logic [15:0]      rne_res;

  // One rounder serves both operand feedback paths and the final capture.
  goldschmidt_ctrl_rne u_rne (
    .x (dp_result[FRAC_PROD:0]),
    .y (rne_res)
  );

  // Operand bypass: feedback products reach the datapath in their landing cycle
  always_comb begin
    dp_ia = ia_r;
    dp_d  = d_r;
    dp_n  = n_r;
    if (state == ISSUE_D && iter != '0) dp_d = rne_res;
    if (state == ISSUE_N && iter != '0) dp_n = rne_res;
  end

  // Control FSM with registered handshake and datapath-select outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      iter         <= '0;
      n_r          <= '0;
      d_r          <= '0;
      ia_r         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero     <= 1'b0;
      quotient     <= '0;
      quotient_raw <= '0;
      dp_ndselect  <= 1'b1;
      dp_kselect   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_r      <= n_in;
            d_r      <= d_in;
            ia_r     <= ia_in;
            iter     <= '0;
            busy     <= 1'b1;
            if (d_in == 16'h0000) begin
              // Result is fully known now, so it is presented in cycle 1.
              state        <= ZERO;
              done         <= 1'b1;
              div_zero     <= 1'b1;
              quotient     <= SAT_Q15;
              quotient_raw <= '1;
            end else begin
              state       <= ISSUE_D;
              div_zero    <= 1'b0;
              dp_ndselect <= 1'b0;
              dp_kselect  <= 1'b1;
            end
          end
        end
        ISSUE_D: begin
          if (iter != '0) d_r <= rne_res;
          state       <= ISSUE_N;
          dp_ndselect <= 1'b1;
          dp_kselect  <= 1'b0;
        end
        ISSUE_N: begin
          if (iter != '0) n_r <= rne_res;
          iter <= iter + CNT_W'(1);
          if (iter == CNT_W'(ITERS - 1)) begin
            state <= DRAIN;
          end else begin
            state       <= ISSUE_D;
            dp_ndselect <= 1'b0;
          end
        end
        DRAIN: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          quotient_raw <= dp_result;
          quotient     <= rne_res;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        ZERO: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
- Sequencing controller for the Goldschmidt divider datapath (NR/CSAM pipeline with RNE rounder and k generator).
- Accepts a divide request through a start/busy/done handshake and latches the N, D and IA operands.
- Drives the datapath's N, D, IA, kSelect and ndSelect inputs every cycle and feeds rounded D and N products back as the next iteration's operands.
- Captures the final N product as the quotient; sits directly upstream of the datapath and consumes its 32-bit result.

Parameters:
- ITERS, 3, number of Goldschmidt iterations (≥1).
- CNT_W, $clog2(ITERS+1), width of the iteration counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  request; sampled only while idle
- n_in  in  16  dividend, Q1.15
- d_in  in  16  divisor, Q1.15, normalised to [0.5,1): 0x4000..0x7FFF
- ia_in  in  16  initial reciprocal approximation of d_in, Q1.15
- dp_result  in  32  datapath result, Q2.30 product
- dp_n  out  16  to datapath N
- dp_d  out  16  to datapath D
- dp_ia  out  16  to datapath IA
- dp_kselect  out  1  to datapath kSelect
- dp_ndselect  out  1  to datapath ndSelect (1 = N / k hold; 0 = D / k load)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: quotient valid
- div_zero  out  1  set with done when d_in == 0
- quotient  out  16  rounded quotient, Q1.15
- quotient_raw  out  32  unrounded final product, Q2.30

Behaviour:
- Clock and reset: all state is on the rising edge of clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; busy, done and div_zero = 0.
  - quotient = 0, quotient_raw = 0.
  - dp_ndselect = 1, dp_kselect = 0.
  - Operand registers n_r, d_r, ia_r = 0.
- Reset mid-operation: returns to IDLE immediately; no done is issued. The datapath shares the same reset.
- Rounding, rne(x):
  - Take x[30:15] as the result, x[14] as guard, and OR of x[13:0] as sticky.
  - Increment when guard & (sticky | x[15]).
  - Saturate to 0xFFFF on carry-out.
  - Must be bit-identical to the datapath rounder.
- Cycle numbering: cycle 0 is the cycle in which start = 1 while in IDLE. The clock edge that ends cycle 0 latches n_in, d_in and ia_in into n_r, d_r and ia_r.
- Divide by zero: if d_in == 0 at start, go to ZERO instead. In cycle 1 assert done = 1, div_zero = 1, quotient = 0xFFFF, quotient_raw = 0xFFFF_FFFF, then return to IDLE. The datapath is not exercised.
- States: IDLE, ISSUE_D, ISSUE_N, DRAIN, CAPTURE, ZERO.
- Iteration schedule, with iter counting 0..ITERS-1. Each iteration occupies 2 cycles:
  - ISSUE_D, cycle 1+2·iter:
    - dp_ndselect = 0.
    - dp_kselect = 1 when iter == 0, else 0.
    - dp_d = d_r when iter == 0, else rne(dp_result), combinational bypass.
    - On iter > 0, d_r ← rne(dp_result).
  - ISSUE_N, cycle 2+2·iter:
    - dp_ndselect = 1, dp_kselect = 0.
    - dp_n = n_r when iter == 0, else rne(dp_result), combinational bypass.
    - On iter > 0, n_r ← rne(dp_result).
    - Then iter++; go to DRAIN if iter == ITERS, else ISSUE_D.
- Pipeline timing: each product appears on dp_result exactly 2 cycles after its issue.
  - The D·K product lands in the next ISSUE_D cycle, so the datapath's k generator loads 2−D in that same cycle.
  - The N·K product lands in the next ISSUE_N cycle.
- Drain and capture:
  - DRAIN, cycle 2·ITERS+1: dp_ndselect = 1 so k is held; dp_result = D_last·K is ignored.
  - CAPTURE, cycle 2·ITERS+2: dp_ndselect = 1; quotient_raw ← dp_result; quotient ← rne(dp_result).
- Completion, cycle 2·ITERS+3: state = IDLE, done = 1 for exactly one cycle.
- busy:
  - Normal divide: high in cycles 1..2·ITERS+2.
  - ZERO path: high only in cycle 1.
  - Low in the done cycle.
- start is accepted in the done cycle: back-to-back operations are allowed. start while busy is ignored and does not alter the in-flight operands.
- Output stability: quotient, quotient_raw and div_zero hold their values until the next done. div_zero clears on the next accepted start.
- Other outputs: dp_ia = ia_r at all times. dp_n and dp_d hold n_r and d_r outside their issue cycles.
- Latency: fixed at 2·ITERS+3 cycles from start to done; 9 cycles for ITERS = 3.

Decomposition:
- Shared package (div_pkg):
  - State enum ctrl_state_t.
  - Q-format constants: FRAC_IN = 15, FRAC_PROD = 30, ONE_Q15 = 16'h8000, SAT_Q15 = 16'hFFFF.
- Sub-module: one instance of the team's existing RNE rounder for rne(dp_result). It is reused in CAPTURE and in the bypass paths.
- Counter and FSM: stay in this module.

Test Plan:
- Nominal divide: ITERS = 3, N = 0x4000, D = 0x6000, IA = 0xAAAB, with the real datapath.
  - Required: done in cycle 9; quotient = 0x5555 ±1 LSB; div_zero = 0.
- Control trace for the same run:
  - dp_ndselect over cycles 1..8 = 0,1,0,1,0,1,1,1.
  - dp_kselect = 1 in cycle 1 only.
  - dp_d in cycle 3 equals rne(dp_result).
- Unit quotient: N = D = 0x6000, IA = 0xAAAB.
  - Required: quotient = 0x8000 ±1 LSB; quotient_raw[31:30] = 2'b00 or 2'b01.
- Divide by zero: d_in = 0x0000 with start.
  - Required: cycle 1 done = 1, div_zero = 1, quotient = 0xFFFF, busy = 1 in cycle 1 only.
  - dp_ndselect stays 1 throughout.
- Handshake:
  - start pulsed in cycles 3 and 5 with different operands → ignored; result matches the first operands.
  - start in the done cycle → second divide completes 9 cycles later.
- Reset mid-operation: assert reset in cycle 4.
  - Required: busy = 0 and dp_ndselect = 1 immediately; done is never pulsed; the next start runs normally.
